// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and the writeback source-select type for the register-file
// writeback scheduler.
package regfile_wb_scheduler_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MUL = 1'b1
  } src_sel_e;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Issue, writeback-source and register-file write-port bundle for the scheduler.
// The slave modport is the scheduler's view; master is the surrounding pipeline.
interface regfile_wb_scheduler_if;
  import regfile_wb_scheduler_pkg::*;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic              issue_wb_en;
  logic [ADDR_W-1:0] issue_rs1;
  logic              issue_rs1_used;
  logic [ADDR_W-1:0] issue_rs2;
  logic              issue_rs2_used;
  logic              issue_stall;

  logic              src0_valid;
  logic [ADDR_W-1:0] src0_addr;
  logic [DATA_W-1:0] src0_data;
  logic              src0_ready;
  logic              src1_valid;
  logic [ADDR_W-1:0] src1_addr;
  logic [DATA_W-1:0] src1_data;
  logic              src1_ready;

  logic              rf_write_en;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic [NUM_REGS-1:0] busy_vec;

  modport slave (
    input  issue_valid, issue_rd, issue_wb_en, issue_rs1, issue_rs1_used,
           issue_rs2, issue_rs2_used,
    input  src0_valid, src0_addr, src0_data, src1_valid, src1_addr, src1_data,
    output issue_stall, src0_ready, src1_ready,
    output rf_write_en, rf_write_addr, rf_write_data, busy_vec
  );

  modport master (
    output issue_valid, issue_rd, issue_wb_en, issue_rs1, issue_rs1_used,
           issue_rs2, issue_rs2_used,
    output src0_valid, src0_addr, src0_data, src1_valid, src1_addr, src1_data,
    input  issue_stall, src0_ready, src1_ready,
    input  rf_write_en, rf_write_addr, rf_write_data, busy_vec
  );
endinterface

// File: rtl/regfile_wb_scheduler_wb_rr_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port.
// last_grant starts at SRC_MUL so the ALU wins the first tie.
module wb_rr_arbiter
  import regfile_wb_scheduler_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);
  src_sel_e last_grant_q;
  src_sel_e last_grant_d;

  // Grant selection and next last_grant
  always_comb begin
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    last_grant_d = last_grant_q;
    if (reset) begin
      last_grant_d = SRC_MUL;
    end else if (req0 && req1) begin
      if (last_grant_q == SRC_MUL) begin
        gnt0         = 1'b1;
        last_grant_d = SRC_ALU;
      end else begin
        gnt1         = 1'b1;
        last_grant_d = SRC_MUL;
      end
    end else if (req0) begin
      gnt0         = 1'b1;
      last_grant_d = SRC_ALU;
    end else if (req1) begin
      gnt1         = 1'b1;
      last_grant_d = SRC_MUL;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // last_grant register
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= SRC_MUL;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file writeback scheduler: round-robin write-port arbitration plus a
// per-register busy scoreboard that stalls issue on RAW/WAW hazards.
// Optional macro WB_BYPASS_EN lifts a hazard in the cycle its register commits.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_scheduler_if.slave bus
);
  logic                gnt0_s;
  logic                gnt1_s;
  logic                wr_en_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic                rs1_haz_s;
  logic                rs2_haz_s;
  logic                rd_haz_s;
  logic                stall_s;
  logic                accept_s;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .req0  (bus.src0_valid),
    .req1  (bus.src1_valid),
    .gnt0  (gnt0_s),
    .gnt1  (gnt1_s)
  );

  // Write-port mux from the granted source
  always_comb begin
    wr_en_s   = gnt0_s | gnt1_s;
    wr_addr_s = {ADDR_W{1'b0}};
    wr_data_s = {DATA_W{1'b0}};
    if (gnt0_s) begin
      wr_addr_s = bus.src0_addr;
      wr_data_s = bus.src0_data;
    end else if (gnt1_s) begin
      wr_addr_s = bus.src1_addr;
      wr_data_s = bus.src1_data;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Hazard detection; with bypass, a register committing this cycle is readable
  always_comb begin
    rs1_haz_s = bus.issue_rs1_used && busy_q[bus.issue_rs1];
    rs2_haz_s = bus.issue_rs2_used && busy_q[bus.issue_rs2];
    rd_haz_s  = bus.issue_wb_en    && busy_q[bus.issue_rd];
`ifdef WB_BYPASS_EN
    if (wr_en_s) begin
      rs1_haz_s = rs1_haz_s && (wr_addr_s != bus.issue_rs1);
      rs2_haz_s = rs2_haz_s && (wr_addr_s != bus.issue_rs2);
      rd_haz_s  = rd_haz_s  && (wr_addr_s != bus.issue_rd);
    end else begin
      rd_haz_s  = rd_haz_s;
    end
`endif
    stall_s  = bus.issue_valid && !reset && (rs1_haz_s || rs2_haz_s || rd_haz_s);
    accept_s = bus.issue_valid && !stall_s;
  end

  // Scoreboard next state: commit clears, accepted issue sets (set wins)
  always_comb begin
    busy_d = busy_q;
    if (wr_en_s) begin
      busy_d[wr_addr_s] = 1'b0;
    end else begin
      busy_d[wr_addr_s] = busy_q[wr_addr_s];
    end
    if (accept_s && bus.issue_wb_en && (bus.issue_rd != {ADDR_W{1'b0}})) begin
      busy_d[bus.issue_rd] = 1'b1;
    end else begin
      busy_d[bus.issue_rd] = busy_d[bus.issue_rd];
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= {NUM_REGS{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.src0_ready    = gnt0_s;
  assign bus.src1_ready    = gnt1_s;
  assign bus.rf_write_en   = wr_en_s;
  assign bus.rf_write_addr = wr_addr_s;
  assign bus.rf_write_data = wr_data_s;
  assign bus.issue_stall   = stall_s;
  assign bus.busy_vec      = busy_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler; stall-timing
// expectations follow WB_BYPASS_EN when the build defines it.
module tb_regfile_wb_scheduler;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   s0;
  int   s1;

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
  localparam logic BYP_STALL = 1'b0;
`else
  localparam logic BYP_STALL = 1'b1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 1'b0; bus.issue_rd = 5'd0; bus.issue_wb_en = 1'b0;
    bus.issue_rs1 = 5'd0; bus.issue_rs1_used = 1'b0;
    bus.issue_rs2 = 5'd0; bus.issue_rs2_used = 1'b0;
    bus.src0_valid = 1'b0; bus.src0_addr = 5'd0; bus.src0_data = 32'd0;
    bus.src1_valid = 1'b0; bus.src1_addr = 5'd0; bus.src1_data = 32'd0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wb, input logic [4:0] rs1, input logic rs1u);
    bus.issue_valid = 1'b1; bus.issue_rd = rd; bus.issue_wb_en = wb;
    bus.issue_rs1 = rs1; bus.issue_rs1_used = rs1u;
    bus.issue_rs2 = 5'd0; bus.issue_rs2_used = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; s0 = 0; s1 = 0;
    idle_inputs();
    reset = 1'b1;
    step();
    // Requests during reset must be ignored
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd6; bus.src0_data = 32'h1234_5678;
    bus.src1_valid = 1'b1; bus.src1_addr = 5'd8; bus.src1_data = 32'h8765_4321;
    issue(5'd3, 1'b1, 5'd0, 1'b0);
    #1;
    check("rst_src0_ready", {31'd0, bus.src0_ready}, 32'd0);
    check("rst_src1_ready", {31'd0, bus.src1_ready}, 32'd0);
    check("rst_wr_en", {31'd0, bus.rf_write_en}, 32'd0);
    check("rst_wr_addr", {27'd0, bus.rf_write_addr}, 32'd0);
    check("rst_wr_data", bus.rf_write_data, 32'd0);
    check("rst_stall", {31'd0, bus.issue_stall}, 32'd0);
    step();
    check("rst_busy", bus.busy_vec, 32'd0);
    idle_inputs();
    reset = 1'b0;
    step();

    // Single ALU write, zero latency
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd5; bus.src0_data = 32'hA5A5_A5A5;
    #1;
    check("alu_ready", {31'd0, bus.src0_ready}, 32'd1);
    check("alu_wr_en", {31'd0, bus.rf_write_en}, 32'd1);
    check("alu_wr_addr", {27'd0, bus.rf_write_addr}, 32'd5);
    check("alu_wr_data", bus.rf_write_data, 32'hA5A5_A5A5);
    step();
    idle_inputs();

    // Lone src1 write; leaves last_grant at src1
    bus.src1_valid = 1'b1; bus.src1_addr = 5'd30; bus.src1_data = 32'hDEAD_BEEF;
    #1;
    check("mul_ready", {31'd0, bus.src1_ready}, 32'd1);
    check("mul_alu_ready", {31'd0, bus.src0_ready}, 32'd0);
    check("mul_wr_addr", {27'd0, bus.rf_write_addr}, 32'd30);
    check("mul_wr_data", bus.rf_write_data, 32'hDEAD_BEEF);
    step();

    // Contention: grants alternate src0, src1, src0, src1
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd1;
    bus.src1_valid = 1'b1; bus.src1_addr = 5'd2;
    for (int k = 0; k < 4; k++) begin
      bus.src0_data = 32'h100 + s0;
      bus.src1_data = 32'h200 + s1;
      #1;
      check("cont_ready0", {31'd0, bus.src0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_ready1", {31'd0, bus.src1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      check("cont_wr_addr", {27'd0, bus.rf_write_addr}, (k % 2 == 0) ? 32'd1 : 32'd2);
      check("cont_wr_data", bus.rf_write_data, (k % 2 == 0) ? (32'h100 + s0) : (32'h200 + s1));
      if (k % 2 == 0) s0++; else s1++;
      step();
    end
    idle_inputs();
    check("cont_busy", bus.busy_vec, 32'd0);

    // RAW hazard on x7
    issue(5'd7, 1'b1, 5'd0, 1'b0);
    #1;
    check("raw_first_stall", {31'd0, bus.issue_stall}, 32'd0);
    step();
    check("raw_busy7", bus.busy_vec, 32'h0000_0080);
    issue(5'd0, 1'b0, 5'd7, 1'b1);
    #1;
    check("raw_stall_a", {31'd0, bus.issue_stall}, 32'd1);
    step();
    check("raw_stall_b", {31'd0, bus.issue_stall}, 32'd1);
    bus.src1_valid = 1'b1; bus.src1_addr = 5'd7; bus.src1_data = 32'h0000_0777;
    #1;
    check("raw_commit_ready", {31'd0, bus.src1_ready}, 32'd1);
    check("raw_stall_n", {31'd0, bus.issue_stall}, {31'd0, BYP_STALL});
    step();
    bus.src1_valid = 1'b0;
    #1;
    check("raw_stall_n1", {31'd0, bus.issue_stall}, 32'd0);
    check("raw_busy_clr", bus.busy_vec, 32'd0);
    step();
    idle_inputs();

    // WAW hazard on x9
    issue(5'd9, 1'b1, 5'd0, 1'b0);
    step();
    #1;
    check("waw_stall_a", {31'd0, bus.issue_stall}, 32'd1);
    step();
    check("waw_stall_b", {31'd0, bus.issue_stall}, 32'd1);
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd9; bus.src0_data = 32'h0000_0999;
    #1;
    check("waw_stall_n", {31'd0, bus.issue_stall}, {31'd0, BYP_STALL});
    step();
    bus.src0_valid = 1'b0;
    #1;
    if (BYP_STALL) begin
      check("waw_stall_n1", {31'd0, bus.issue_stall}, 32'd0);
      step();
    end else begin
      check("waw_bypass_busy", bus.busy_vec, 32'h0000_0200);
    end
    check("waw_busy9", bus.busy_vec, 32'h0000_0200);
    idle_inputs();
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd9; bus.src0_data = 32'h0000_0990;
    step();
    idle_inputs();
    check("waw_busy_clr", bus.busy_vec, 32'd0);

    // x0 never becomes busy
    issue(5'd0, 1'b1, 5'd0, 1'b0);
    #1;
    check("x0_wb_stall", {31'd0, bus.issue_stall}, 32'd0);
    step();
    check("x0_busy", bus.busy_vec, 32'd0);
    issue(5'd0, 1'b0, 5'd0, 1'b1);
    #1;
    check("x0_rs1_stall", {31'd0, bus.issue_stall}, 32'd0);
    step();
    idle_inputs();

    // Same-cycle commit and issue of x4: set wins
    issue(5'd4, 1'b1, 5'd0, 1'b0);
    bus.src0_valid = 1'b1; bus.src0_addr = 5'd4; bus.src0_data = 32'h0000_0444;
    #1;
    check("sc_stall", {31'd0, bus.issue_stall}, 32'd0);
    step();
    idle_inputs();
    check("sc_busy4", bus.busy_vec, 32'h0000_0010);

    // Reset mid-operation
    issue(5'd3, 1'b1, 5'd0, 1'b0);
    step();
    issue(5'd12, 1'b1, 5'd0, 1'b0);
    step();
    check("mid_busy", bus.busy_vec, 32'h0000_1018);
    issue(5'd0, 1'b0, 5'd3, 1'b1);
    bus.src1_valid = 1'b1; bus.src1_addr = 5'd12; bus.src1_data = 32'h0000_0CCC;
    #1;
    check("mid_stall_pre", {31'd0, bus.issue_stall}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_ready1", {31'd0, bus.src1_ready}, 32'd0);
    check("mid_rst_wr_en", {31'd0, bus.rf_write_en}, 32'd0);
    check("mid_rst_stall", {31'd0, bus.issue_stall}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("mid_busy_clr", bus.busy_vec, 32'd0);
    check("mid_stall_post", {31'd0, bus.issue_stall}, 32'd0);
    check("mid_ready1_post", {31'd0, bus.src1_ready}, 32'd1);
    step();
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
